control_fsm: RTL

Multi-cycle instruction sequencer for the 16-bit, 8-register processor. It sits directly upstream of the datapath slice array. It fetches each instruction word over SysBus and holds it in an instruction register (IR). It then drives the slice control strobes (register one-hots, ALU/shift selects, PC controls), and it also runs the memory request/acknowledge handshake for fetch, load and store.

---
 rtl/control_fsm_if.sv | 11 +
 rtl/control_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
// Memory-side handshake bundle between the instruction sequencer and SysBus.
// The sequencer is the master; the memory model/controller is the slave.
interface control_fsm_if;
  logic [15:0] SysBus;
  logic        MemAck;
  logic        MemReq;
  logic        MemWrite;

  modport master (input SysBus, MemAck, output MemReq, MemWrite);
  modport slave  (output SysBus, MemAck, input MemReq, MemWrite);
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for the 16-bit/8-register core: fetches into IR and
// drives datapath slice strobes plus the fetch/load/store memory handshake.
module control_fsm (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Z,
  control_fsm_if.master       bus,
  output logic [7:0]          Rs1,
  output logic [7:0]          Rs2,
  output logic [7:0]          Rw,
  output logic                AND,
  output logic                OR,
  output logic                XOR,
  output logic                NOT,
  output logic                SUB,
  output logic                Op1Sel,
  output logic [1:0]          Op2Sel,
  output logic [15:0]         Imm,
  output logic                ShL,
  output logic                ShR,
  output logic                Sh1,
  output logic                Sh2,
  output logic                Sh4,
  output logic                Sh8,
  output logic                AluOut,
  output logic                ShOut,
  output logic                WdSel,
  output logic                PcWe,
  output logic [2:0]          PcSel,
  output logic                PcEn,
  output logic                Illegal
);

  typedef enum logic [1:0] {FETCH, EXEC, LOAD, STORE} state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic [7:0] rs1;
    logic [7:0] rs2;
    logic [7:0] rw;
    logic       f_and;
    logic       f_or;
    logic       f_xor;
    logic       f_not;
    logic       f_sub;
    logic       op1_sel;
    logic [1:0] op2_sel;
    logic [15:0] imm;
    logic       sh_l;
    logic       sh_r;
    logic [3:0] sh_amt;
    logic       alu_out;
    logic       sh_out;
    logic       wd_sel;
    logic       pc_we;
    logic [2:0] pc_sel;
    logic       pc_en;
    logic       illegal;
  } ctrl_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
                         OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_ADDI = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8,  OP_LDW = 4'd9,  OP_STW = 4'd10, OP_BR  = 4'd11,
                         OP_BNZ = 4'd12, OP_JMP = 4'd13, OP_NOP = 4'd15;

  localparam logic [1:0] OP2_IMM = 2'd1;
  localparam logic [2:0] PC_INC = 3'd0, PC_RES = 3'd1, PC_RD1 = 3'd2;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        ir_ld;
  ctrl_t       c;

  logic [3:0] op;
  logic [2:0] fd, fa, fb;
  logic [7:0] sel_d, sel_a, sel_b;

  assign op    = ir[15:12];
  assign fd    = ir[11:9];
  assign fa    = ir[8:6];
  assign fb    = ir[5:3];
  assign sel_d = 8'b1 << fd;
  assign sel_a = 8'b1 << fa;
  assign sel_b = 8'b1 << fb;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (ir_ld) ir <= bus.SysBus;
    end
  end

  // Everything is gated by Reset so an in-flight request is dropped in the reset cycle.
  always_comb begin
    state_nxt = state;
    ir_ld     = 1'b0;
    c         = '0;
    if (!Reset) begin
      unique case (state)
        FETCH: begin
          c.mem_req = 1'b1;
          c.pc_en   = 1'b1;
          if (bus.MemAck) begin
            ir_ld     = 1'b1;
            c.pc_we   = 1'b1;
            c.pc_sel  = PC_INC;
            state_nxt = EXEC;
          end
        end
        EXEC: begin
          state_nxt = FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              c.rs1     = sel_a;
              c.rs2     = sel_b;
              c.rw      = sel_d;
              c.alu_out = 1'b1;
              c.f_sub   = (op == OP_SUB);
              c.f_and   = (op == OP_AND);
              c.f_or    = (op == OP_OR);
              c.f_xor   = (op == OP_XOR);
            end
            OP_NOT: begin
              c.rs1   = sel_a;
              c.rw    = sel_d;
              c.f_not = 1'b1;
            end
            OP_ADDI: begin
              c.rs1     = sel_d;
              c.rw      = sel_d;
              c.op2_sel = OP2_IMM;
              c.imm     = {8'h00, ir[7:0]};
            end
            OP_SHL, OP_SHR: begin
              c.rs1    = sel_a;
              c.rw     = sel_d;
              c.sh_out = 1'b1;
              c.sh_l   = (op == OP_SHL);
              c.sh_r   = (op == OP_SHR);
              c.sh_amt = ir[3:0];
            end
            OP_LDW: state_nxt = LOAD;
            OP_STW: state_nxt = STORE;
            OP_BR, OP_BNZ: begin
              c.op1_sel = 1'b1;
              c.op2_sel = OP2_IMM;
              c.imm     = {{8{ir[7]}}, ir[7:0]};
              c.alu_out = 1'b1;
              c.pc_sel  = PC_RES;
              c.pc_we   = (op == OP_BR) ? 1'b1 : ~Z;
            end
            OP_JMP: begin
              c.rs1    = sel_a;
              c.pc_sel = PC_RD1;
              c.pc_we  = 1'b1;
            end
            OP_NOP: ;
            default: c.illegal = 1'b1;
          endcase
        end
        LOAD: begin
          c.mem_req = 1'b1;
          c.rs1     = sel_a;
          if (bus.MemAck) begin
            c.rw      = sel_d;
            c.wd_sel  = 1'b1;
            state_nxt = FETCH;
          end
        end
        STORE: begin
          c.mem_req = 1'b1;
          c.mem_wr  = 1'b1;
          c.rs1     = sel_a;
          c.rs2     = sel_d;
          if (bus.MemAck) state_nxt = FETCH;
        end
      endcase
    end
  end

  assign bus.MemReq   = c.mem_req;
  assign bus.MemWrite = c.mem_wr;
  assign Rs1     = c.rs1;
  assign Rs2     = c.rs2;
  assign Rw      = c.rw;
  assign AND     = c.f_and;
  assign OR      = c.f_or;
  assign XOR     = c.f_xor;
  assign NOT     = c.f_not;
  assign SUB     = c.f_sub;
  assign Op1Sel  = c.op1_sel;
  assign Op2Sel  = c.op2_sel;
  assign Imm     = c.imm;
  assign ShL     = c.sh_l;
  assign ShR     = c.sh_r;
  assign {Sh8, Sh4, Sh2, Sh1} = c.sh_amt;
  assign AluOut  = c.alu_out;
  assign ShOut   = c.sh_out;
  assign WdSel   = c.wd_sel;
  assign PcWe    = c.pc_we;
  assign PcSel   = c.pc_sel;
  assign PcEn    = c.pc_en;
  assign Illegal = c.illegal;

endmodule
